// File: rtl/shift_unit_pkg.sv
// Shared types and helpers for the shift/rotate execution unit.
// Holds the opcode and FSM state encodings plus the effective-amount rule.
package shift_unit_pkg;

    typedef enum logic [2:0] {
        OP_SHL         = 3'd0,
        OP_SHR         = 3'd1,
        OP_SAR         = 3'd2,
        OP_ROL         = 3'd3,
        OP_ROR         = 3'd4,
        OP_ILLEGAL_MIN = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op < OP_ILLEGAL_MIN;
    endfunction

    function automatic logic op_is_rotate(input logic [2:0] op);
        return (op == OP_ROL) || (op == OP_ROR);
    endfunction

    // Shifts saturate at the operand width; rotates keep the raw amount and
    // simply iterate, so no modulo divider is needed.
    function automatic int unsigned eff_amount(input logic [2:0] op,
                                               input int unsigned amount,
                                               input int unsigned width);
        if (!op_is_legal(op)) begin
            return 0;
        end
        if (op_is_rotate(op)) begin
            return amount;
        end
        return (amount > width) ? width : amount;
    endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Request/response bundle between decode, the shift unit and writeback.
// master = requester side, slave = shift unit side.
interface shift_unit_if #(
    parameter int WIDTH     = 12,
    parameter int AMT_WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_op;
    logic [WIDTH-1:0]     in_value;
    logic [AMT_WIDTH-1:0] in_amount;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_value;
    logic                 out_lost;
    logic                 out_illegal;

    modport master (
        output in_valid, in_op, in_value, in_amount, out_ready,
        input  in_ready, out_valid, out_value, out_lost, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_value, in_amount, out_ready,
        output in_ready, out_valid, out_value, out_lost, out_illegal
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves acc by k (0..STEP) positions
// and flags whether any 1 bit fell off the end.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter  int WIDTH = 12,
    parameter  int STEP  = 4,
    localparam int KW    = $clog2(STEP + 1)
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] res,
    output logic             lost
);

    logic [2*WIDTH-1:0] up;
    logic [2*WIDTH-1:0] dn;

    always_comb begin
        up   = {{WIDTH{1'b0}}, acc} << k;
        dn   = {acc, {WIDTH{1'b0}}} >> k;
        res  = acc;
        lost = 1'b0;
        case (op)
            OP_SHL: begin
                res  = up[WIDTH-1:0];
                lost = |up[2*WIDTH-1:WIDTH];
            end
            OP_SHR: begin
                res  = dn[2*WIDTH-1:WIDTH];
                lost = |dn[WIDTH-1:0];
            end
            OP_SAR: begin
                // acc's MSB is still the original sign because every SAR step refills it
                res  = dn[2*WIDTH-1:WIDTH] |
                       (acc[WIDTH-1] ? ~({WIDTH{1'b1}} >> k) : {WIDTH{1'b0}});
                lost = |dn[WIDTH-1:0];
            end
            OP_ROL: res = WIDTH'(({acc, acc} << k) >> WIDTH);
            OP_ROR: res = WIDTH'({acc, acc} >> k);
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP bit positions per BUSY cycle.
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   BUSY  | shifting acc, rem positions left to go
//   DONE  | result held on out_*, waiting for out_ready
module shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH     = 12,
    parameter int AMT_WIDTH = 8,
    parameter int STEP      = 4
) (
    input  logic          clock,
    input  logic          reset,
    shift_unit_if.slave   bus,
    output logic          busy
);

    localparam int                   KW     = $clog2(STEP + 1);
    localparam logic [AMT_WIDTH-1:0] STEP_A = AMT_WIDTH'(STEP);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [AMT_WIDTH-1:0] rem_q, rem_d;
    logic [2:0]           op_q, op_d;
    logic                 lost_acc_q, lost_acc_d;
    logic                 ready_q, ready_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 res_lost_q, res_lost_d;
    logic                 res_illegal_q, res_illegal_d;

    logic [AMT_WIDTH-1:0] amt_eff;
    logic [AMT_WIDTH-1:0] k_full;
    logic [KW-1:0]        k;
    logic [WIDTH-1:0]     step_res;
    logic                 step_lost;

    always_comb begin
        amt_eff = AMT_WIDTH'(eff_amount(bus.in_op, 32'(bus.in_amount), WIDTH));
        k_full  = (rem_q > STEP_A) ? STEP_A : rem_q;
    end

    assign k = KW'(k_full);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .op   (op_q),
        .acc  (acc_q),
        .k    (k),
        .res  (step_res),
        .lost (step_lost)
    );

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        rem_d         = rem_q;
        op_d          = op_q;
        lost_acc_d    = lost_acc_q;
        res_d         = res_q;
        res_lost_d    = res_lost_q;
        res_illegal_d = res_illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && ready_q) begin
                    op_d       = bus.in_op;
                    acc_d      = bus.in_value;
                    rem_d      = amt_eff;
                    lost_acc_d = 1'b0;
                    if (amt_eff == '0) begin
                        state_d       = DONE;
                        res_d         = bus.in_value;
                        res_lost_d    = 1'b0;
                        res_illegal_d = !op_is_legal(bus.in_op);
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d      = step_res;
                rem_d      = rem_q - k_full;
                lost_acc_d = lost_acc_q | step_lost;
                if (rem_d == '0) begin
                    state_d       = DONE;
                    res_d         = step_res;
                    res_lost_d    = lost_acc_q | step_lost;
                    res_illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered so that in_ready is low for the whole time reset is held
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            rem_q         <= '0;
            op_q          <= '0;
            lost_acc_q    <= 1'b0;
            ready_q       <= 1'b0;
            res_q         <= '0;
            res_lost_q    <= 1'b0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            rem_q         <= rem_d;
            op_q          <= op_d;
            lost_acc_q    <= lost_acc_d;
            ready_q       <= ready_d;
            res_q         <= res_d;
            res_lost_q    <= res_lost_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = (state_q == DONE);
    assign bus.out_value   = res_q;
    assign bus.out_lost    = res_lost_q;
    assign bus.out_illegal = res_illegal_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=12, AMT_WIDTH=8, STEP=4) with
// hand-computed results and latencies.
module tb_shift_unit;

    logic clock;
    logic reset;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    shift_unit_if #(.WIDTH(12), .AMT_WIDTH(8)) bus ();

    shift_unit #(
        .WIDTH     (12),
        .AMT_WIDTH (8),
        .STEP      (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure edges from accept to out_valid, check the
    // result, and optionally hand it off to the consumer.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [11:0] val,
                         input logic [7:0] amt, input logic [11:0] ev, input logic el,
                         input logic ei, input int elat, input bit drain);
        int n;
        int lat;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_op     = op;
        bus.in_value  = val;
        bus.in_amount = amt;
        bus.in_valid  = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_value  = ~val;
        bus.in_amount = 8'hFF;
        bus.in_op     = 3'd0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_value"}, 32'(bus.out_value), 32'(ev));
        chk({tag, "_lost"}, 32'(bus.out_lost), 32'(el));
        chk({tag, "_illegal"}, 32'(bus.out_illegal), 32'(ei));
        if (drain) begin
            @(negedge clock);
            bus.out_ready = 1'b1;
            @(posedge clock);
            #1;
            bus.out_ready = 1'b0;
            chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
            chk({tag, "_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic seen;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_value  = 12'h000;
        bus.in_amount = 8'd0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_value", 32'(bus.out_value), 32'd0);
        chk("rst_out_lost", 32'(bus.out_lost), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        do_op("shl_1_1",     3'd0, 12'h001, 8'd1,  12'h002, 1'b0, 1'b0, 2, 1'b1);
        do_op("shl_801_4",   3'd0, 12'h801, 8'd4,  12'h010, 1'b1, 1'b0, 2, 1'b1);
        do_op("sar_800_20",  3'd2, 12'h800, 8'd20, 12'hFFF, 1'b1, 1'b0, 4, 1'b1);
        do_op("shr_800_20",  3'd1, 12'h800, 8'd20, 12'h000, 1'b1, 1'b0, 4, 1'b1);
        do_op("sar_7f0_4",   3'd2, 12'h7F0, 8'd4,  12'h07F, 1'b0, 1'b0, 2, 1'b1);
        do_op("ror_001_13",  3'd4, 12'h001, 8'd13, 12'h800, 1'b0, 1'b0, 5, 1'b1);
        do_op("rol_801_0",   3'd3, 12'h801, 8'd0,  12'h801, 1'b0, 1'b0, 1, 1'b1);
        do_op("rol_801_5",   3'd3, 12'h801, 8'd5,  12'h030, 1'b0, 1'b0, 3, 1'b1);

        // Backpressure: result must hold while a competing request is offered
        do_op("bp_shl_3_1",  3'd0, 12'h003, 8'd1,  12'h006, 1'b0, 1'b0, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.in_valid  = 1'b1;
            bus.in_op     = 3'd1;
            bus.in_value  = 12'hFFF;
            bus.in_amount = 8'd0;
            @(posedge clock);
            #1;
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_value", 32'(bus.out_value), 32'h006);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        do_op("bp_next_shr", 3'd1, 12'hF00, 8'd4,  12'h0F0, 1'b0, 1'b0, 2, 1'b1);

        // Reset in the middle of a long rotate
        @(negedge clock);
        bus.in_op     = 3'd3;
        bus.in_value  = 12'h123;
        bus.in_amount = 8'd40;
        bus.in_valid  = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        chk("mid_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_rst_out_value", 32'(bus.out_value), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            seen = seen | bus.out_valid;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        do_op("post_rst_shl", 3'd0, 12'h003, 8'd2, 12'h00C, 1'b0, 1'b0, 2, 1'b1);

        do_op("illegal_6",   3'd6, 12'h5A5, 8'd9,  12'h5A5, 1'b0, 1'b1, 1, 1'b1);
        do_op("after_ill",   3'd0, 12'h0F0, 8'd12, 12'h000, 1'b1, 1'b0, 4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
